multi_channel_smoother: RTL and testbench
=========================================

# multi_channel_smoother

Parametrised multi-channel glitch filter for quantised sensor samples in the AVS acquisition chain, placed between the per-channel sample formatter and the direction-estimation logic. Each channel holds its output until a new value has appeared on DEPTH consecutive valid samples, which rejects single- and multi-sample glitches. The block adds a valid handshake, a runtime bypass mode and per-channel change strobes.

## Interface
- BUS, 6, width of one channel sample in bits (1..32)
- CHANNELS, 4, number of independent channels packed in the data buses (1..16)
- DEPTH, 3, consecutive equal valid samples required to accept a new value (2..16)
- clock  input  1  system clock; all logic is on the rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  datain carries a new sample set this cycle
- bypass  input  1  1 = pass samples straight through; 0 = filter
- datain  input  CHANNELS*BUS  channel c occupies bits [c*BUS +: BUS]
- dataout  output  CHANNELS*BUS  filtered samples, same packing as datain
- out_valid  output  1  registered copy of in_valid
- changed  output  CHANNELS  one-cycle strobe; bit c is 1 when dataout channel c took a different value this update

## Operation
- Per-channel state:
  - candidate[BUS]: the value currently being checked.
  - run: the number of consecutive valid samples equal to candidate, saturating at DEPTH; width clog2(DEPTH+1).
  - out register: the channel's dataout.
- Reset (reset=1 at an edge; overrides all other inputs, including mid-run):
  - dataout=0, candidate=0, run=0, out_valid=0, changed=0.
- in_valid=0: all state holds, out_valid=0, changed=0.
- in_valid=1, bypass=0, for each channel with sample s:
  - If s==candidate: run <= min(run+1, DEPTH).
  - If s!=candidate: candidate <= s and run <= 1.
  - If the new run value equals DEPTH: out <= s. Otherwise out holds.
  - changed[c] = 1 only when out is written with a value different from its old value.
  - While run is saturated, out is rewritten with the same value and changed stays 0.
- in_valid=1, bypass=1, for each channel:
  - out <= s, candidate <= s, run <= DEPTH.
  - changed[c] = (s != old out).
  - Leaving bypass therefore keeps the last value, and a new value must again persist for DEPTH samples.
- Channels are fully independent: no shared counters, and no cross-channel effect of a glitch.
- Equality is a full BUS-bit compare; there is no tolerance window.
- Start-up: after reset, candidate=0 with run=0, so a first sample of 0 counts as run 1, not as a mismatch.

## Timing
- All outputs are registered.
- Filtering, bypass=0: dataout reflects the DEPTH-th equal sample in the cycle after that sample was accepted.
  - Latency from the first sample of a new value is DEPTH valid samples plus 1 clock.
  - Invalid cycles in between do not break a run; they only stretch wall-clock latency.
- Bypass: latency is 1 clock.
- out_valid and changed are asserted in the same cycle as the dataout update they describe, for exactly 1 clock per accepted input.
- A glitch shorter than DEPTH samples never reaches dataout.
- A glitch of exactly DEPTH samples is passed.
- Back-to-back valid inputs on every clock are supported; throughput is 1 sample set per clock.
- bypass is sampled only on in_valid cycles, and can change on any cycle.
- reset asserted together with in_valid: reset wins and the sample is discarded.

## Test plan
- Reset then hold, DEPTH=3, ch0: after reset, drive 0,0,0 valid -> dataout 0 throughout; changed=0 and out_valid=1 on the 3 output cycles.
- Acceptance latency, ch0: after a stable 0, drive 5,5,5 valid on consecutive clocks -> dataout ch0 becomes 5 one clock after the third 5; changed[0]=1 for that single cycle.
- Glitch rejection, ch1:
  - stable 9, then 12,12,9,9,9 -> dataout ch1 stays 9; changed[1]=0.
  - then 12,12,12 -> dataout ch1 becomes 12.
- Gapped valid, ch2: 7, idle, 7, idle, idle, 7 -> dataout ch2 becomes 7 one clock after the last 7; out_valid pulses only on the 3 valid cycles.
- Bypass: with bypass=1, drive 1,2,3 valid on ch3 -> dataout ch3 is 1,2,3 with 1-clock latency and changed[3] pulses each time; then bypass=0 and drive 4,4 -> dataout stays 3.
- Reset mid-run, ch0: out=5, then 8,8 valid, reset for 1 clock, then 8 valid -> dataout 0 after reset and still 0 after the single 8; it becomes 8 only after two more valid 8s.

Source files
------------

// File: rtl/multi_channel_smoother.sv
// Purpose: per-channel glitch filter; a new value reaches dataout after DEPTH consecutive equal valid samples.
// Latency: DEPTH valid samples + 1 clock when filtering, 1 clock in bypass; all outputs registered.
// Backpressure: none; accepts one sample set per clock whenever in_valid is high.
module multi_channel_smoother #(
  parameter int BUS      = 6,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     bypass,
  input  logic [CHANNELS*BUS-1:0]  datain,
  output logic [CHANNELS*BUS-1:0]  dataout,
  output logic                     out_valid,
  output logic [CHANNELS-1:0]      changed
);

  // Run counter saturates at DEPTH, so it needs to hold values 0..DEPTH.
  localparam int RW = $clog2(DEPTH + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(DEPTH);

  logic [BUS-1:0]      samp    [CHANNELS];
  logic [BUS-1:0]      cand_q  [CHANNELS];
  logic [BUS-1:0]      cand_d  [CHANNELS];
  logic [RW-1:0]       run_q   [CHANNELS];
  logic [RW-1:0]       run_d   [CHANNELS];
  logic [BUS-1:0]      out_q   [CHANNELS];
  logic [BUS-1:0]      out_d   [CHANNELS];
  logic [CHANNELS-1:0] changed_q;
  logic [CHANNELS-1:0] changed_d;
  logic                out_valid_q;

  // Unpack the input bus and pack the output registers, channel c at [c*BUS +: BUS].
  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan_io
    assign samp[g]                  = datain[g*BUS +: BUS];
    assign dataout[g*BUS +: BUS]    = out_q[g];
  end

  // Per-channel next state: bypass forces the sample through and primes the run as
  // saturated; filtering counts consecutive equal samples and commits on reaching DEPTH.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      cand_d[c]    = cand_q[c];
      run_d[c]     = run_q[c];
      out_d[c]     = out_q[c];
      changed_d[c] = 1'b0;
      if (in_valid) begin
        if (bypass) begin
          cand_d[c]    = samp[c];
          run_d[c]     = RUN_MAX;
          out_d[c]     = samp[c];
          changed_d[c] = (samp[c] != out_q[c]);
        end else begin
          if (samp[c] == cand_q[c]) begin
            run_d[c] = (run_q[c] == RUN_MAX) ? RUN_MAX : run_q[c] + 1'b1;
          end else begin
            cand_d[c] = samp[c];
            run_d[c]  = {{(RW-1){1'b0}}, 1'b1};
          end
          // While saturated the output is rewritten with the same value, so no strobe.
          if (run_d[c] == RUN_MAX) begin
            out_d[c]     = samp[c];
            changed_d[c] = (samp[c] != out_q[c]);
          end
        end
      end
    end
  end

  // State registers; reset has priority over any sample presented in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        cand_q[c] <= '0;
        run_q[c]  <= '0;
        out_q[c]  <= '0;
      end
      changed_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cand_q      <= cand_d;
      run_q       <= run_d;
      out_q       <= out_d;
      changed_q   <= changed_d;
      out_valid_q <= in_valid;
    end
  end

  assign changed   = changed_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multi_channel_smoother.sv
// Purpose: directed table-driven check of multi_channel_smoother with default parameters.
// Latency: each vector is applied before a rising edge and the outputs compared 1 time unit after it.
// Backpressure: not applicable; the DUT has none.
module tb_multi_channel_smoother;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        bypass;
  logic [23:0] datain;
  logic [23:0] dataout;
  logic        out_valid;
  logic [3:0]  changed;

  int n_pass;
  int n_total;

  multi_channel_smoother #(.BUS(6), .CHANNELS(4), .DEPTH(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .bypass    (bypass),
    .datain    (datain),
    .dataout   (dataout),
    .out_valid (out_valid),
    .changed   (changed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        rst;
    logic        vld;
    logic        byp;
    logic [23:0] din;
    logic [23:0] edout;
    logic        evld;
    logic [3:0]  echg;
  } vec_t;

  vec_t vecs[$];

  // Pack four channel values, ch3 in the top bits.
  function automatic logic [23:0] pk(input int a3, input int a2, input int a1, input int a0);
    return {a3[5:0], a2[5:0], a1[5:0], a0[5:0]};
  endfunction

  function automatic vec_t mk(input string nm, input logic r, input logic v, input logic b,
                              input logic [23:0] d, input logic [23:0] ed,
                              input logic ev, input logic [3:0] ec);
    vec_t t;
    t.name = nm; t.rst = r; t.vld = v; t.byp = b;
    t.din = d; t.edout = ed; t.evld = ev; t.echg = ec;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clock);
    reset    = v.rst;
    in_valid = v.vld;
    bypass   = v.byp;
    datain   = v.din;
    @(posedge clock);
    #1;
    chk({v.name, ".dataout"},   dataout,          v.edout);
    chk({v.name, ".out_valid"}, 24'(out_valid),   24'(v.evld));
    chk({v.name, ".changed"},   24'(changed),     24'(v.echg));
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    bypass   = 1'b0;
    datain   = '0;

    // Reset with a valid sample present: reset wins.
    vecs.push_back(mk("reset_wins", 1, 1, 0, pk(1,1,1,1), pk(0,0,0,0), 0, 4'b0000));
    // Start-up: zeros count as a run, output stays 0 with no strobe.
    vecs.push_back(mk("hold0_1", 0, 1, 0, pk(0,0,0,0), pk(0,0,0,0), 1, 4'b0000));
    vecs.push_back(mk("hold0_2", 0, 1, 0, pk(0,0,0,0), pk(0,0,0,0), 1, 4'b0000));
    vecs.push_back(mk("hold0_3", 0, 1, 0, pk(0,0,0,0), pk(0,0,0,0), 1, 4'b0000));
    // Acceptance on ch0 after the third 5.
    vecs.push_back(mk("acc5_1", 0, 1, 0, pk(0,0,0,5), pk(0,0,0,0), 1, 4'b0000));
    vecs.push_back(mk("acc5_2", 0, 1, 0, pk(0,0,0,5), pk(0,0,0,0), 1, 4'b0000));
    vecs.push_back(mk("acc5_3", 0, 1, 0, pk(0,0,0,5), pk(0,0,0,5), 1, 4'b0001));
    vecs.push_back(mk("acc5_sat", 0, 1, 0, pk(0,0,0,5), pk(0,0,0,5), 1, 4'b0000));
    // ch1 settles on 9.
    vecs.push_back(mk("ch1_9_1", 0, 1, 0, pk(0,0,9,5), pk(0,0,0,5), 1, 4'b0000));
    vecs.push_back(mk("ch1_9_2", 0, 1, 0, pk(0,0,9,5), pk(0,0,0,5), 1, 4'b0000));
    vecs.push_back(mk("ch1_9_3", 0, 1, 0, pk(0,0,9,5), pk(0,0,9,5), 1, 4'b0010));
    // Two-sample glitch of 12 is rejected; re-acquiring 9 gives no strobe.
    vecs.push_back(mk("glitch_12a", 0, 1, 0, pk(0,0,12,5), pk(0,0,9,5), 1, 4'b0000));
    vecs.push_back(mk("glitch_12b", 0, 1, 0, pk(0,0,12,5), pk(0,0,9,5), 1, 4'b0000));
    vecs.push_back(mk("back9_1", 0, 1, 0, pk(0,0,9,5), pk(0,0,9,5), 1, 4'b0000));
    vecs.push_back(mk("back9_2", 0, 1, 0, pk(0,0,9,5), pk(0,0,9,5), 1, 4'b0000));
    vecs.push_back(mk("back9_3", 0, 1, 0, pk(0,0,9,5), pk(0,0,9,5), 1, 4'b0000));
    // Exactly DEPTH samples of 12 pass.
    vecs.push_back(mk("acc12_1", 0, 1, 0, pk(0,0,12,5), pk(0,0,9,5), 1, 4'b0000));
    vecs.push_back(mk("acc12_2", 0, 1, 0, pk(0,0,12,5), pk(0,0,9,5), 1, 4'b0000));
    vecs.push_back(mk("acc12_3", 0, 1, 0, pk(0,0,12,5), pk(0,0,12,5), 1, 4'b0010));
    // Gapped valid on ch2; idle data and bypass are ignored.
    vecs.push_back(mk("gap7_1", 0, 1, 0, pk(0,7,12,5), pk(0,0,12,5), 1, 4'b0000));
    vecs.push_back(mk("gap_idle1", 0, 0, 0, pk(0,63,63,63), pk(0,0,12,5), 0, 4'b0000));
    vecs.push_back(mk("gap7_2", 0, 1, 0, pk(0,7,12,5), pk(0,0,12,5), 1, 4'b0000));
    vecs.push_back(mk("gap_idle2", 0, 0, 0, pk(0,63,63,63), pk(0,0,12,5), 0, 4'b0000));
    vecs.push_back(mk("gap_idle3", 0, 0, 1, pk(63,0,0,0), pk(0,0,12,5), 0, 4'b0000));
    vecs.push_back(mk("gap7_3", 0, 1, 0, pk(0,7,12,5), pk(0,7,12,5), 1, 4'b0100));
    // Bypass on ch3, then filtering resumes from the last bypassed value.
    vecs.push_back(mk("byp_1", 0, 1, 1, pk(1,7,12,5), pk(1,7,12,5), 1, 4'b1000));
    vecs.push_back(mk("byp_2", 0, 1, 1, pk(2,7,12,5), pk(2,7,12,5), 1, 4'b1000));
    vecs.push_back(mk("byp_3", 0, 1, 1, pk(3,7,12,5), pk(3,7,12,5), 1, 4'b1000));
    vecs.push_back(mk("post_byp4_1", 0, 1, 0, pk(4,7,12,5), pk(3,7,12,5), 1, 4'b0000));
    vecs.push_back(mk("post_byp4_2", 0, 1, 0, pk(4,7,12,5), pk(3,7,12,5), 1, 4'b0000));
    vecs.push_back(mk("post_byp4_3", 0, 1, 0, pk(4,7,12,5), pk(4,7,12,5), 1, 4'b1000));
    // Reset mid-run on ch0: the partial run of 8 is lost.
    vecs.push_back(mk("mid8_1", 0, 1, 0, pk(4,7,12,8), pk(4,7,12,5), 1, 4'b0000));
    vecs.push_back(mk("mid8_2", 0, 1, 0, pk(4,7,12,8), pk(4,7,12,5), 1, 4'b0000));
    vecs.push_back(mk("mid_reset", 1, 1, 0, pk(4,7,12,8), pk(0,0,0,0), 0, 4'b0000));
    vecs.push_back(mk("after_rst8_1", 0, 1, 0, pk(0,0,0,8), pk(0,0,0,0), 1, 4'b0000));
    vecs.push_back(mk("after_rst8_2", 0, 1, 0, pk(0,0,0,8), pk(0,0,0,0), 1, 4'b0000));
    vecs.push_back(mk("after_rst8_3", 0, 1, 0, pk(0,0,0,8), pk(0,0,0,8), 1, 4'b0001));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Independence: ch0 glitches to full-scale 63 and recovers while ch1 accepts 33.
    run_vec(mk("indep_1", 0, 1, 0, pk(0,0,33,63), pk(0,0,0,8),  1, 4'b0000));
    run_vec(mk("indep_2", 0, 1, 0, pk(0,0,33,8),  pk(0,0,0,8),  1, 4'b0000));
    run_vec(mk("indep_3", 0, 1, 0, pk(0,0,33,8),  pk(0,0,33,8), 1, 4'b0010));
    run_vec(mk("indep_4", 0, 1, 0, pk(0,0,0,8),   pk(0,0,33,8), 1, 4'b0000));

    // Idle after activity: out_valid and changed drop, data holds.
    run_vec(mk("final_idle", 0, 0, 0, pk(9,9,9,9), pk(0,0,33,8), 0, 4'b0000));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
